// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_pkg;

    localparam int FP_MAX_W = 64;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (32'sd1 << (exp_w - 32'sd1)) - 32'sd1;
    endfunction

    // Canonical quiet NaN: sign 0, all-ones exponent, only the fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int frac_w);
        logic [FP_MAX_W-1:0] v;
        v = (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 32'sd1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage: round-to-nearest-even, range checks, special-value packing, flags.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W,
    localparam int EW    = EXP_W + 2
) (
    input  logic                 i_sign,
    input  logic signed [EW-1:0] i_exp,
    input  logic [FRAC_W:0]      i_sig,
    input  logic                 i_g,
    input  logic                 i_r,
    input  logic                 i_s,
    input  fp_class_e            i_class,
    output logic [W-1:0]         o_f,
    output fp_flags_t            o_flags
);

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, FRAC_W);
    localparam logic signed [EW-1:0] E_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
    localparam logic signed [EW-1:0] E_MAX  = {2'b00, {EXP_W{1'b1}}};

    logic                 w_inc;
    logic [FRAC_W+1:0]    w_sum;
    logic [FRAC_W-1:0]    w_frac;
    logic signed [EW-1:0] w_exp;

    // Rounding increment; a carry out of the significand renormalises by one.
    always_comb begin
        w_inc = i_g & (i_r | i_s | i_sig[0]);
        w_sum = {1'b0, i_sig} + {{(FRAC_W+1){1'b0}}, w_inc};
        if (w_sum[FRAC_W+1]) begin
            w_frac = w_sum[FRAC_W:1];
            w_exp  = i_exp + E_ONE;
        end else begin
            w_frac = w_sum[FRAC_W-1:0];
            w_exp  = i_exp;
        end
    end

    // Result selection by class, then overflow/flush-to-zero for finite products.
    always_comb begin
        o_f     = {W{1'b0}};
        o_flags = '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
        case (i_class)
            NAN: begin
                o_f             = QNAN_FULL[W-1:0];
                o_flags.invalid = 1'b1;
            end
            INF: begin
                o_f = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end
            ZERO: begin
                o_f = {i_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            end
            NORM: begin
                if (w_exp >= E_MAX) begin
                    o_f              = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    o_flags.overflow = 1'b1;
                    o_flags.inexact  = 1'b1;
                end else if (w_exp <= E_ZERO) begin
                    o_f               = {i_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
                    o_flags.underflow = 1'b1;
                    o_flags.inexact   = 1'b1;
                end else begin
                    o_f             = {i_sign, w_exp[EXP_W-1:0], w_frac};
                    o_flags.inexact = i_g | i_r | i_s;
                end
            end
            default: begin
                o_f     = {W{1'b0}};
                o_flags = '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier: operand capture, classify/multiply, normalise, round/pack.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     f,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags
);

    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 2;
    localparam logic signed [EW-1:0] E_BIAS = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] E_ONE  = {{(EW-1){1'b0}}, 1'b1};

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] m);
        if (e == {EXP_W{1'b0}})      return ZERO;
        else if (e == {EXP_W{1'b1}}) return (m == {FRAC_W{1'b0}}) ? INF : NAN;
        else                         return NORM;
    endfunction

    logic w_en;

    logic             r0_valid;
    logic [W-1:0]     r0_a, r0_b;
    logic [TAG_W-1:0] r0_tag;

    fp_class_e            w_cls_a, w_cls_b, w_cls1;
    logic signed [EW-1:0] w_exp1;
    logic [PROD_W-1:0]    w_prod1;

    logic                 r1_valid, r1_sign;
    logic [TAG_W-1:0]     r1_tag;
    fp_class_e            r1_class;
    logic signed [EW-1:0] r1_exp;
    logic [PROD_W-1:0]    r1_prod;

    logic [PROD_W-1:0]    w_norm2;
    logic signed [EW-1:0] w_exp2;

    logic                 r2_valid, r2_sign, r2_g, r2_r, r2_s;
    logic [TAG_W-1:0]     r2_tag;
    fp_class_e            r2_class;
    logic signed [EW-1:0] r2_exp;
    logic [FRAC_W:0]      r2_sig;

    logic [W-1:0]     w_f3;
    fp_flags_t        w_flags3;
    logic             r_out_valid;
    logic [W-1:0]     r_f;
    logic [TAG_W-1:0] r_tag;
    fp_flags_t        r_flags;

    assign w_en      = !r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign f         = r_f;
    assign out_tag   = r_tag;
    assign flags     = r_flags;

    // Operand capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid <= 1'b0;
            r0_a     <= {W{1'b0}};
            r0_b     <= {W{1'b0}};
            r0_tag   <= {TAG_W{1'b0}};
        end else if (w_en) begin
            r0_valid <= in_valid;
            r0_a     <= a;
            r0_b     <= b;
            r0_tag   <= in_tag;
        end
    end

    // S1: classify both operands, pick the special-case result class, multiply significands.
    always_comb begin
        w_cls_a = classify(r0_a[W-2:FRAC_W], r0_a[FRAC_W-1:0]);
        w_cls_b = classify(r0_b[W-2:FRAC_W], r0_b[FRAC_W-1:0]);
        if (w_cls_a == NAN || w_cls_b == NAN ||
            (w_cls_a == ZERO && w_cls_b == INF) || (w_cls_a == INF && w_cls_b == ZERO)) begin
            w_cls1 = NAN;
        end else if (w_cls_a == INF || w_cls_b == INF) begin
            w_cls1 = INF;
        end else if (w_cls_a == ZERO || w_cls_b == ZERO) begin
            w_cls1 = ZERO;
        end else begin
            w_cls1 = NORM;
        end
        w_exp1  = $signed({2'b00, r0_a[W-2:FRAC_W]}) + $signed({2'b00, r0_b[W-2:FRAC_W]}) - E_BIAS;
        w_prod1 = {{SIG_W{1'b0}}, 1'b1, r0_a[FRAC_W-1:0]} * {{SIG_W{1'b0}}, 1'b1, r0_b[FRAC_W-1:0]};
    end

    // S1 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_tag   <= {TAG_W{1'b0}};
            r1_class <= ZERO;
            r1_exp   <= {EW{1'b0}};
            r1_prod  <= {PROD_W{1'b0}};
        end else if (w_en) begin
            r1_valid <= r0_valid;
            r1_sign  <= r0_a[W-1] ^ r0_b[W-1];
            r1_tag   <= r0_tag;
            r1_class <= w_cls1;
            r1_exp   <= w_exp1;
            r1_prod  <= w_prod1;
        end
    end

    // S2: left-align the product so the hidden bit sits in the MSB.
    always_comb begin
        if (r1_prod[PROD_W-1]) begin
            w_norm2 = r1_prod;
            w_exp2  = r1_exp + E_ONE;
        end else begin
            w_norm2 = {r1_prod[PROD_W-2:0], 1'b0};
            w_exp2  = r1_exp;
        end
    end

    // S2 pipeline register: kept significand plus guard, round and sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_tag   <= {TAG_W{1'b0}};
            r2_class <= ZERO;
            r2_exp   <= {EW{1'b0}};
            r2_sig   <= {SIG_W{1'b0}};
            r2_g     <= 1'b0;
            r2_r     <= 1'b0;
            r2_s     <= 1'b0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_tag   <= r1_tag;
            r2_class <= r1_class;
            r2_exp   <= w_exp2;
            r2_sig   <= w_norm2[PROD_W-1:FRAC_W+1];
            r2_g     <= w_norm2[FRAC_W];
            r2_r     <= w_norm2[FRAC_W-1];
            r2_s     <= |w_norm2[FRAC_W-2:0];
        end
    end

    fp_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .i_sign  (r2_sign),
        .i_exp   (r2_exp),
        .i_sig   (r2_sig),
        .i_g     (r2_g),
        .i_r     (r2_r),
        .i_s     (r2_s),
        .i_class (r2_class),
        .o_f     (w_f3),
        .o_flags (w_flags3)
    );

    // S3 output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_f         <= {W{1'b0}};
            r_tag       <= {TAG_W{1'b0}};
            r_flags     <= '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
        end else if (w_en) begin
            r_out_valid <= r2_valid;
            r_f         <= w_f3;
            r_tag       <= r2_tag;
            r_flags     <= w_flags3;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench: vector table through a scoreboard, plus latency, stall and reset sequences.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, f;
    logic [3:0]  in_tag, out_tag, flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_f;
    logic [3:0]  h_tag, h_out_tag, h_flags;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .out_tag(out_tag), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(5), .FRAC_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .in_tag(h_tag), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .f(h_f), .out_tag(h_out_tag), .flags(h_flags)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] f; logic [3:0] fl; } vec_t;
    typedef struct { logic [31:0] f; logic [3:0] tag; logic [3:0] fl; } exp_t;

    vec_t        vt [17];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_f;
    logic [3:0]  exp_fl;

    logic        prev_stall = 1'b0;
    logic [31:0] pf;
    logic [3:0]  ptag, pfl;
    exp_t        e;

    // Monitor: handshake rule, stall stability, scoreboard push and pop.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            n_vec++;
            if (in_ready !== (!out_valid | out_ready)) begin
                n_err++;
                $display("FAIL in_ready: got %b want %b", in_ready, !out_valid | out_ready);
            end
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || f !== pf || out_tag !== ptag || flags !== pfl) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b f=%h tag=%h fl=%b want v=1 f=%h tag=%h fl=%b",
                             out_valid, f, out_tag, flags, pf, ptag, pfl);
                end
            end
            if (in_valid && in_ready) sb.push_back('{exp_f, in_tag, exp_fl});
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got f=%h tag=%h, want none", f, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (f !== e.f || out_tag !== e.tag || flags !== e.fl) begin
                        n_err++;
                        $display("FAIL result: got f=%h tag=%h fl=%b want f=%h tag=%h fl=%b",
                                 f, out_tag, flags, e.f, e.tag, e.fl);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            pf = f; ptag = out_tag; pfl = flags;
        end
    end

    task automatic send(input vec_t v, input logic [3:0] tg);
        a = v.a; b = v.b; in_tag = tg; exp_f = v.f; exp_fl = v.fl; in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 want 1 (tag %h)", tg);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic h_run(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] ef,
                         input logic [3:0] efl);
        h_a = ta; h_b = tb_; h_tag = 4'd5; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (h_out_valid !== 1'b1 || h_f !== ef || h_out_tag !== 4'd5 || h_flags !== efl) begin
            n_err++;
            $display("FAIL half %h*%h: got v=%b f=%h tag=%h fl=%b want v=1 f=%h tag=5 fl=%b",
                     ta, tb_, h_out_valid, h_f, h_out_tag, h_flags, ef, efl);
        end
    endtask

    initial begin
        logic seen;
        vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
        vt[1]  = '{32'h3FC00000, 32'h40600000, 32'h40A80000, 4'b0000};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vt[3]  = '{32'h3E000000, 32'h41000000, 32'h3F800000, 4'b0000};
        vt[4]  = '{32'h40000000, 32'h00000000, 32'h00000000, 4'b0000};
        vt[5]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        vt[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vt[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vt[8]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
        vt[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        vt[10] = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001};
        vt[11] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
        vt[12] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
        vt[13] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
        vt[14] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000};
        vt[15] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000};
        vt[16] = '{32'hFF000000, 32'h40000000, 32'hFF800000, 4'b0101};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; in_tag = 4'd0;
        exp_f = 32'd0; exp_fl = 4'd0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = 16'd0; h_b = 16'd0; h_tag = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || f !== 32'd0 || out_tag !== 4'd0 || flags !== 4'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got v=%b f=%h tag=%h fl=%b rdy=%b want 0/0/0/0/1",
                     out_valid, f, out_tag, flags, in_ready);
        end
        @(posedge clk); #1;

        // Basic latency: three empty sample points, then the result.
        send(vt[0], 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL latency_early: got out_valid=%b at step %0d want 0", out_valid, k);
            end
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || f !== 32'h40C00000 || out_tag !== 4'd3 || flags !== 4'd0) begin
            n_err++;
            $display("FAIL latency_basic: got v=%b f=%h tag=%h fl=%b want 1 40c00000 3 0000",
                     out_valid, f, out_tag, flags);
        end
        @(posedge clk); #1;
        drain();
        @(posedge clk); #1;

        // Full table, streamed back to back.
        for (int i = 0; i < 17; i++) send(vt[i], 4'(i));
        drain();
        @(posedge clk); #1;

        // Backpressure: in_valid held high while out_ready toggles randomly.
        fork
            begin
                for (int i = 0; i < 8; i++) send(vt[(i * 3 + 1) % 17], 4'(i + 8));
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;

        // Reset with three operations in flight.
        send(vt[1], 4'd1);
        send(vt[2], 4'd2);
        send(vt[3], 4'd4);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flush: got out_valid=%b want 0", out_valid);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ghost: got seen=%b want 0", seen);
        end
        @(posedge clk); #1;

        // Half-precision instance.
        h_run(16'h4000, 16'h4200, 16'h4600, 4'b0000);
        h_run(16'h4000, 16'h0000, 16'h0000, 4'b0000);
        h_run(16'h8000, 16'h4000, 16'h8000, 4'b0000);
        h_run(16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
        h_run(16'h7E01, 16'h3C00, 16'h7E00, 4'b1000);
        h_run(16'h7800, 16'h4000, 16'h7C00, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, fully pipelined IEEE-754 binary floating-point multiplier with valid/ready handshake, round-to-nearest-even, special-value handling and exception flags. It is the successor to the fixed 32-bit `MULTI_32bit` multiplier. It is dropped into datapaths that need any exponent/fraction width, one result per cycle, and backpressure from a downstream consumer.

## Interface
- `EXP_W`, 8, exponent field width (≥3)
- `FRAC_W`, 23, stored fraction width (≥2); word width `W = 1+EXP_W+FRAC_W`
- `TAG_W`, 4, sideband tag width carried with each operation
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: operand pair offered
- `in_ready` out 1: block accepts the offered pair this cycle
- `a`, `b` in W: IEEE-format operands
- `in_tag` in TAG_W: opaque tag, returned with the result
- `out_valid` out 1: result available
- `out_ready` in 1: consumer takes the result this cycle
- `f` out W: product
- `out_tag` out TAG_W: tag of this result
- `flags` out 4: {invalid, overflow, underflow, inexact}

## Operation
- `BIAS = 2^(EXP_W-1)-1`. `EMAX = 2^EXP_W-1` is the all-ones exponent.
- Classify each operand:
  - ZERO: exp=0. Subnormal inputs are treated as zero (DAZ).
  - INF: exp=EMAX, frac=0.
  - NAN: exp=EMAX, frac≠0.
  - NORM: otherwise.
- Result sign = sign(a) XOR sign(b), except for NaN results.
- Special cases take priority, in this order:
  - Any NAN, or ZERO×INF: canonical qNaN (sign 0, exp EMAX, frac MSB 1, rest 0); invalid=1.
  - Any INF: signed infinity; no flags.
  - Any ZERO: signed zero; no flags.
- NORM×NORM:
  - Significand product is `(1.fa)×(1.fb)`, 2·FRAC_W+2 bits.
  - Exponent `e = ea+eb-BIAS`, computed signed in EXP_W+2 bits.
  - If the product MSB is set: shift right 1 and e+1.
  - Keep FRAC_W fraction bits plus guard, round and sticky (OR of all lower bits).
- Rounding is RNE: increment when G & (R | S | LSB). If the increment carries out of the significand, shift right 1 and e+1. inexact = G|R|S.
- Overflow: e ≥ EMAX after rounding gives signed infinity; overflow=1, inexact=1.
- Underflow: e ≤ 0 gives signed zero (flush to zero, no subnormal outputs); underflow=1, inexact=1.
- Tag travels unmodified alongside its operation.

## Timing
- 3 pipeline stages:
  - S1: classify and multiply.
  - S2: normalise and G/R/S.
  - S3: round, pack and flags.
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+3 when there is no stall.
- Throughput: 1 operation per cycle.
- Handshake:
  - Global enable `en = !out_valid | out_ready`, and `in_ready = en`.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - While `en=0`, every stage register (data, valid, tag) holds.
  - out_valid, f, out_tag and flags are stable until taken.
- Bubbles propagate as invalid stages. They do not collapse under stall.
- Reset: all stage valids=0, out_valid=0, f=0, out_tag=0, flags=0, in_ready=1 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight operations. No partial result ever appears.
- in_valid while in_ready=0: the pair is not captured, and the source must hold it.
- in_valid and out_ready may be asserted together with a full pipe: the pipe advances by one, so input and output transfer in the same cycle.

## Structure
- Shared package `fp_pkg` holds:
  - `fp_class_e` enum {ZERO, NORM, INF, NAN}
  - `fp_flags_t` packed struct {invalid, overflow, underflow, inexact}
  - functions `fp_bias(EXP_W)` and `fp_qnan(EXP_W,FRAC_W)`
- Sub-module `fp_round_pack` implements S3: it takes sign, exponent, significand, G/R/S and class, and produces f and flags. It is combinational and registered by the parent.
- Classification and multiplication stay in `fp_mul_pipe`.

## Test plan
All cases use default parameters unless stated.

- Basic: reset, then a=0x40000000, b=0x40400000, tag=3, out_ready=1. Expected: exactly 3 cycles later f=0x40C00000, out_tag=3, flags=0.
- Rounding and inexact:
  - 0x3FC00000 × 0x40600000 gives 0x40A80000, flags=0.
  - 0x3F800001 × 0x3F800001 gives 0x3F800002, inexact=1.
  - 0x3E000000 × 0x41000000 gives 0x3F800000.
- Specials:
  - 0x40000000 × 0x00000000 gives 0x00000000.
  - 0x80000000 × 0x40000000 gives 0x80000000.
  - 0x7F800000 × 0x00000000 gives 0x7FC00000, invalid=1.
  - 0x7FC00001 × 0x3F800000 gives 0x7FC00000, invalid=1.
- Range:
  - 0x7F000000 × 0x40000000 gives 0x7F800000, overflow=1 and inexact=1.
  - 0x00800000 × 0x3F000000 gives 0x00000000, underflow=1 and inexact=1.
- Backpressure: stream 8 tagged operations with in_valid held high and out_ready toggling in a pseudo-random pattern. Expected:
  - every result arrives in order with its tag;
  - nothing is lost or duplicated;
  - outputs are stable while stalled;
  - in_ready = !out_valid | out_ready.
- Reset mid-flight and parameters:
  - Assert rst with 3 operations in flight: out_valid=0 the next cycle, and none of those results ever appear.
  - Rerun the basic and specials cases with EXP_W=5, FRAC_W=10: 0x4000 × 0x4200 gives 0x4600.
